// File: rtl/sdram_req_arbiter_if.sv
// ---------------------------------------------------------------------------
// sdram_req_arbiter_if
//   Handshake bundle between the SDRAM request arbiter, its two requesters
//   (video read path, host write path) and the controller application port.
//
//   Parameters: AW - app port address width, DW - data width.
//
//   Modports:
//     master - the arbiter's view: it consumes requests and drives the
//              controller request fields and the ack/done pulses.
//     slave  - the environment's view: requesters and controller.
// ---------------------------------------------------------------------------
interface sdram_req_arbiter_if #(
  parameter int AW = 25,
  parameter int DW = 16
);
  // Video read requester
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_urgent;
  logic          rd_ack;
  logic          rd_done;
  // Host write requester
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ack;
  logic          wr_done;
  // Controller application port
  logic          app_req;
  logic [AW-1:0] app_req_addr;
  logic [8:0]    app_req_len;
  logic          app_req_wr_n;
  logic [DW-1:0] app_wr_data;
  logic          app_req_ack;
  logic          app_last_rd;
  logic          app_last_wr;

  modport master (
    input  rd_req, rd_addr, rd_urgent,
    input  wr_req, wr_addr, wr_data,
    input  app_req_ack, app_last_rd, app_last_wr,
    output rd_ack, rd_done, wr_ack, wr_done,
    output app_req, app_req_addr, app_req_len, app_req_wr_n, app_wr_data
  );

  modport slave (
    output rd_req, rd_addr, rd_urgent,
    output wr_req, wr_addr, wr_data,
    output app_req_ack, app_last_rd, app_last_wr,
    input  rd_ack, rd_done, wr_ack, wr_done,
    input  app_req, app_req_addr, app_req_len, app_req_wr_n, app_wr_data
  );
endinterface

// File: rtl/sdram_req_arbiter.sv
// ---------------------------------------------------------------------------
// sdram_req_arbiter
//   Shares the single SDRAM controller application port between the video
//   read requester (RD_LEN-word bursts) and the host write path (single-word
//   writes). One transaction outstanding at a time. Reads win by default;
//   a starvation counter forces a write after WR_STARVE consecutive reads
//   (unless the read is urgent), and a watchdog aborts a transaction whose
//   ack or completion never arrives.
//
//   Ports:
//     i_mem_clk      memory clock, all logic on rising edge
//     i_reset        synchronous, active-high reset
//     i_mem_ready    controller init done; no grants while low
//     bus            requester / controller handshake bundle (master view)
//     o_busy         high whenever the arbiter is not idle
//     o_timeout_err  sticky watchdog-abort flag, cleared only by reset
//
//   All outputs are registered.
// ---------------------------------------------------------------------------
module sdram_req_arbiter #(
  parameter int AW        = 25,
  parameter int DW        = 16,
  parameter int RD_LEN    = 8,
  parameter int WR_STARVE = 16,
  parameter int TIMEOUT   = 255
) (
  input  logic                       i_mem_clk,
  input  logic                       i_reset,
  input  logic                       i_mem_ready,
  sdram_req_arbiter_if.master        bus,
  output logic                       o_busy,
  output logic                       o_timeout_err
);

  localparam int              SCW        = $clog2(WR_STARVE + 1);
  localparam logic [SCW-1:0]  STARVE_MAX = SCW'(WR_STARVE);
  localparam logic [8:0]      LEN_RD     = 9'(RD_LEN);
  // Abort fires on the edge at which the watchdog would reach TIMEOUT, so the
  // arbiter spends exactly TIMEOUT cycles out of IDLE before giving up.
  localparam logic [7:0]      WD_LAST    = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_RD,
    S_WAIT_WR
  } state_t;

  state_t         r_state,       w_state;
  logic           r_app_req,     w_app_req;
  logic [AW-1:0]  r_addr,        w_addr;
  logic [8:0]     r_len,         w_len;
  logic           r_wr_n,        w_wr_n;
  logic [DW-1:0]  r_wdata,       w_wdata;
  logic           r_rd_ack,      w_rd_ack;
  logic           r_wr_ack,      w_wr_ack;
  logic           r_rd_done,     w_rd_done;
  logic           r_wr_done,     w_wr_done;
  logic           r_busy,        w_busy;
  logic           r_timeout_err, w_timeout_err;
  logic [SCW-1:0] r_starve,      w_starve;
  logic [7:0]     r_wd,          w_wd;

  logic           w_rd_win;
  logic           w_wd_expired;

  // Read wins unless a write is also waiting and has been passed over
  // WR_STARVE times; an urgent read overrides the starvation guard.
  assign w_rd_win     = bus.rd_req &&
                        (!bus.wr_req || bus.rd_urgent || (r_starve < STARVE_MAX));
  assign w_wd_expired = (r_wd >= WD_LAST);

  // Next-state and next-output logic.
  // NOTE: every variable gets a default at the top of the block so that no
  // path leaves it unassigned -- otherwise synthesis infers a latch.
  always_comb begin
    w_state       = r_state;
    w_app_req     = r_app_req;
    w_addr        = r_addr;
    w_len         = r_len;
    w_wr_n        = r_wr_n;
    w_wdata       = r_wdata;
    w_rd_ack      = 1'b0;
    w_wr_ack      = 1'b0;
    w_rd_done     = 1'b0;
    w_wr_done     = 1'b0;
    w_timeout_err = r_timeout_err;
    w_starve      = r_starve;
    w_wd          = r_wd;

    unique case (r_state)
      S_IDLE: begin
        if (i_mem_ready && (bus.rd_req || bus.wr_req)) begin
          w_state   = S_REQ;
          w_app_req = 1'b1;
          w_wd      = 8'd0;
          if (w_rd_win) begin
            w_addr = bus.rd_addr;
            w_len  = LEN_RD;
            w_wr_n = 1'b1;
            // Only reads that overtake a waiting write count as starvation.
            if (bus.wr_req && (r_starve < STARVE_MAX)) begin
              w_starve = r_starve + SCW'(1);
            end
          end else begin
            w_addr   = bus.wr_addr;
            w_len    = 9'd1;
            w_wr_n   = 1'b0;
            w_wdata  = bus.wr_data;
            w_starve = '0;
          end
        end
      end

      S_REQ: begin
        w_wd = r_wd + 8'd1;
        // A genuine handshake takes precedence over an abort on the same edge.
        if (bus.app_req_ack) begin
          w_app_req = 1'b0;
          if (r_wr_n) begin
            w_rd_ack = 1'b1;
            w_state  = S_WAIT_RD;
          end else begin
            w_wr_ack = 1'b1;
            w_state  = S_WAIT_WR;
          end
        end else if (w_wd_expired) begin
          w_state       = S_IDLE;
          w_app_req     = 1'b0;
          w_timeout_err = 1'b1;
        end
      end

      S_WAIT_RD: begin
        w_wd = r_wd + 8'd1;
        if (bus.app_last_rd) begin
          w_rd_done = 1'b1;
          w_state   = S_IDLE;
        end else if (w_wd_expired) begin
          w_state       = S_IDLE;
          w_timeout_err = 1'b1;
        end
      end

      S_WAIT_WR: begin
        w_wd = r_wd + 8'd1;
        if (bus.app_last_wr) begin
          w_wr_done = 1'b1;
          w_state   = S_IDLE;
        end else if (w_wd_expired) begin
          w_state       = S_IDLE;
          w_timeout_err = 1'b1;
        end
      end

      default: begin
        w_state   = S_IDLE;
        w_app_req = 1'b0;
      end
    endcase

    // busy is registered from the next state so it tracks r_state exactly.
    w_busy = (w_state != S_IDLE);
  end

  // State and output registers.
  // NOTE: sequential state is updated with non-blocking (<=) assignments so
  // every register samples pre-edge values, independent of statement order.
  always_ff @(posedge i_mem_clk) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_app_req     <= 1'b0;
      r_addr        <= '0;
      r_len         <= 9'd0;
      r_wr_n        <= 1'b1;
      r_wdata       <= '0;
      r_rd_ack      <= 1'b0;
      r_wr_ack      <= 1'b0;
      r_rd_done     <= 1'b0;
      r_wr_done     <= 1'b0;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
      r_starve      <= '0;
      r_wd          <= 8'd0;
    end else begin
      r_state       <= w_state;
      r_app_req     <= w_app_req;
      r_addr        <= w_addr;
      r_len         <= w_len;
      r_wr_n        <= w_wr_n;
      r_wdata       <= w_wdata;
      r_rd_ack      <= w_rd_ack;
      r_wr_ack      <= w_wr_ack;
      r_rd_done     <= w_rd_done;
      r_wr_done     <= w_wr_done;
      r_busy        <= w_busy;
      r_timeout_err <= w_timeout_err;
      r_starve      <= w_starve;
      r_wd          <= w_wd;
    end
  end

  assign bus.app_req      = r_app_req;
  assign bus.app_req_addr = r_addr;
  assign bus.app_req_len  = r_len;
  assign bus.app_req_wr_n = r_wr_n;
  assign bus.app_wr_data  = r_wdata;
  assign bus.rd_ack       = r_rd_ack;
  assign bus.wr_ack       = r_wr_ack;
  assign bus.rd_done      = r_rd_done;
  assign bus.wr_done      = r_wr_done;
  assign o_busy           = r_busy;
  assign o_timeout_err    = r_timeout_err;

endmodule

// File: tb/tb_sdram_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sdram_req_arbiter
//   Directed bench for sdram_req_arbiter. Inputs change 1 ns after a rising
//   edge and outputs are sampled at that same point, so every check sees the
//   result of the edge just taken.
// ---------------------------------------------------------------------------
module tb_sdram_req_arbiter;

  localparam int AW = 25;
  localparam int DW = 16;

  logic clk;
  logic rst;
  logic mem_ready;
  logic busy;
  logic timeout_err;

  int n_chk  = 0;
  int n_pass = 0;

  sdram_req_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  sdram_req_arbiter #(
    .AW(AW), .DW(DW), .RD_LEN(8), .WR_STARVE(16), .TIMEOUT(255)
  ) dut (
    .i_mem_clk    (clk),
    .i_reset      (rst),
    .i_mem_ready  (mem_ready),
    .bus          (bus.master),
    .o_busy       (busy),
    .o_timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.rd_req      = 1'b0;
    bus.rd_addr     = '0;
    bus.rd_urgent   = 1'b0;
    bus.wr_req      = 1'b0;
    bus.wr_addr     = '0;
    bus.wr_data     = '0;
    bus.app_req_ack = 1'b0;
    bus.app_last_rd = 1'b0;
    bus.app_last_wr = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Acts as the controller for one transaction: waits (bounded) for app_req,
  // acks it, then signals completion. Returns the direction seen.
  task automatic serve_one(output logic wr_n, output bit ok);
    for (int i = 0; i < 20 && bus.app_req !== 1'b1; i++) step();
    ok   = (bus.app_req === 1'b1);
    wr_n = bus.app_req_wr_n;
    if (ok) begin
      bus.app_req_ack = 1'b1;
      step();
      bus.app_req_ack = 1'b0;
      if (wr_n) bus.app_last_rd = 1'b1;
      else      bus.app_last_wr = 1'b1;
      step();
      bus.app_last_rd = 1'b0;
      bus.app_last_wr = 1'b0;
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    mem_ready  = 1'b1;
    bus.rd_req = 1'b1;          // must not be granted while reset is held
    rst        = 1'b1;
    step();
    step();
    n_chk++; if (bus.app_req      !== 1'b0)  $display("FAIL rst_app_req: got %b want 0", bus.app_req); else n_pass++;
    n_chk++; if (bus.app_req_addr !== 25'd0) $display("FAIL rst_addr: got %h want 0", bus.app_req_addr); else n_pass++;
    n_chk++; if (bus.app_req_len  !== 9'd0)  $display("FAIL rst_len: got %0d want 0", bus.app_req_len); else n_pass++;
    n_chk++; if (bus.app_req_wr_n !== 1'b1)  $display("FAIL rst_wr_n: got %b want 1", bus.app_req_wr_n); else n_pass++;
    n_chk++; if (bus.app_wr_data  !== 16'd0) $display("FAIL rst_wdata: got %h want 0", bus.app_wr_data); else n_pass++;
    n_chk++; if ({bus.rd_ack, bus.wr_ack, bus.rd_done, bus.wr_done} !== 4'b0)
      $display("FAIL rst_pulses: got %b want 0000", {bus.rd_ack, bus.wr_ack, bus.rd_done, bus.wr_done}); else n_pass++;
    n_chk++; if (busy        !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
    n_chk++; if (timeout_err !== 1'b0) $display("FAIL rst_timeout_err: got %b want 0", timeout_err); else n_pass++;
    bus.rd_req = 1'b0;
    rst        = 1'b0;
    step();
  endtask

  task automatic test_single_read();
    bus.rd_addr = 25'h00100;
    bus.rd_req  = 1'b1;
    step();
    n_chk++; if (bus.app_req      !== 1'b1)      $display("FAIL rd_app_req: got %b want 1", bus.app_req); else n_pass++;
    n_chk++; if (bus.app_req_len  !== 9'd8)      $display("FAIL rd_len: got %0d want 8", bus.app_req_len); else n_pass++;
    n_chk++; if (bus.app_req_wr_n !== 1'b1)      $display("FAIL rd_wr_n: got %b want 1", bus.app_req_wr_n); else n_pass++;
    n_chk++; if (bus.app_req_addr !== 25'h00100) $display("FAIL rd_addr: got %h want 00100", bus.app_req_addr); else n_pass++;
    n_chk++; if (busy             !== 1'b1)      $display("FAIL rd_busy: got %b want 1", busy); else n_pass++;
    step();   // no ack yet: request must be held
    n_chk++; if (bus.app_req !== 1'b1) $display("FAIL rd_req_hold: got %b want 1", bus.app_req); else n_pass++;
    bus.app_req_ack = 1'b1;
    step();
    n_chk++; if ({bus.app_req, bus.rd_ack} !== 2'b01) $display("FAIL rd_ack_edge: got app_req,rd_ack=%b want 01", {bus.app_req, bus.rd_ack}); else n_pass++;
    bus.app_req_ack = 1'b0;
    bus.rd_req      = 1'b0;
    bus.app_last_wr = 1'b1;  // wrong-direction completion must be ignored
    step();
    n_chk++; if ({bus.rd_ack, bus.wr_done, busy} !== 3'b001) $display("FAIL rd_ack_pulse_ignore_wr: got rd_ack,wr_done,busy=%b want 001", {bus.rd_ack, bus.wr_done, busy}); else n_pass++;
    bus.app_last_wr = 1'b0;
    bus.app_last_rd = 1'b1;
    step();
    n_chk++; if ({bus.rd_done, busy} !== 2'b10) $display("FAIL rd_done: got rd_done,busy=%b want 10", {bus.rd_done, busy}); else n_pass++;
    bus.app_last_rd = 1'b0;
    step();
    n_chk++; if (bus.rd_done !== 1'b0) $display("FAIL rd_done_pulse: got %b want 0", bus.rd_done); else n_pass++;
  endtask

  task automatic test_single_write();
    bus.wr_addr = 25'h1ABCD;
    bus.wr_data = 16'hF800;
    bus.wr_req  = 1'b1;
    step();
    n_chk++; if ({bus.app_req, bus.app_req_wr_n} !== 2'b10) $display("FAIL wr_req_dir: got app_req,wr_n=%b want 10", {bus.app_req, bus.app_req_wr_n}); else n_pass++;
    n_chk++; if (bus.app_req_len  !== 9'd1)      $display("FAIL wr_len: got %0d want 1", bus.app_req_len); else n_pass++;
    n_chk++; if (bus.app_req_addr !== 25'h1ABCD) $display("FAIL wr_addr: got %h want 1abcd", bus.app_req_addr); else n_pass++;
    bus.app_req_ack = 1'b1;
    step();
    n_chk++; if ({bus.app_req, bus.wr_ack} !== 2'b01) $display("FAIL wr_ack: got app_req,wr_ack=%b want 01", {bus.app_req, bus.wr_ack}); else n_pass++;
    bus.app_req_ack = 1'b0;
    bus.wr_req      = 1'b0;
    bus.wr_data     = 16'h1234;   // latched word must not follow the input
    bus.app_last_rd = 1'b1;       // ignored in WAIT_WR
    step();
    n_chk++; if (bus.app_wr_data !== 16'hF800) $display("FAIL wr_data_hold: got %h want f800", bus.app_wr_data); else n_pass++;
    n_chk++; if ({bus.rd_done, busy} !== 2'b01) $display("FAIL wr_ignore_rd: got rd_done,busy=%b want 01", {bus.rd_done, busy}); else n_pass++;
    bus.app_last_rd = 1'b0;
    bus.app_last_wr = 1'b1;
    step();
    n_chk++; if ({bus.wr_done, busy} !== 2'b10) $display("FAIL wr_done: got wr_done,busy=%b want 10", {bus.wr_done, busy}); else n_pass++;
    bus.app_last_wr = 1'b0;
    step();
  endtask

  task automatic test_starvation();
    logic wr_n;
    bit   ok;
    clear_inputs();
    do_reset();
    bus.rd_req = 1'b1;
    bus.wr_req = 1'b1;
    for (int i = 0; i < 19; i++) begin
      serve_one(wr_n, ok);
      n_chk++; if (!ok) $display("FAIL starve_grant_timeout: grant %0d never issued", i); else n_pass++;
      n_chk++; if (wr_n !== ((i == 16) ? 1'b0 : 1'b1))
        $display("FAIL starve_dir: grant %0d got wr_n=%b want %b", i, wr_n, (i == 16) ? 1'b0 : 1'b1); else n_pass++;
    end
    bus.rd_req = 1'b0;
    bus.wr_req = 1'b0;
    step();
    step();
  endtask

  task automatic test_urgent();
    logic wr_n;
    bit   ok;
    int   reads;
    clear_inputs();
    do_reset();
    bus.rd_urgent = 1'b1;
    bus.rd_req    = 1'b1;
    bus.wr_req    = 1'b1;
    reads = 0;
    for (int i = 0; i < 20; i++) begin
      serve_one(wr_n, ok);
      if (ok && wr_n === 1'b1) reads++;
    end
    n_chk++; if (reads != 20) $display("FAIL urgent_reads: got %0d reads want 20", reads); else n_pass++;
    // starve count sits saturated, so the first non-urgent grant is a write.
    bus.rd_urgent = 1'b0;
    serve_one(wr_n, ok);
    n_chk++; if (!ok || wr_n !== 1'b0) $display("FAIL urgent_then_write: got ok=%0d wr_n=%b want ok=1 wr_n=0", ok, wr_n); else n_pass++;
    bus.rd_req = 1'b0;
    bus.wr_req = 1'b0;
    step();
  endtask

  task automatic test_watchdog();
    logic wr_n;
    bit   ok;
    bit   saw_done;
    clear_inputs();
    do_reset();
    bus.rd_addr = 25'h00200;
    bus.rd_req  = 1'b1;
    step();                       // grant edge N: app_req from here
    bus.app_req_ack = 1'b1;
    step();                       // edge N+1: acked, now WAIT_RD
    bus.app_req_ack = 1'b0;
    bus.rd_req      = 1'b0;
    saw_done        = 1'b0;
    for (int i = 0; i < 253; i++) begin   // edges N+2 .. N+254
      step();
      if (bus.rd_done === 1'b1) saw_done = 1'b1;
    end
    n_chk++; if ({busy, timeout_err} !== 2'b10) $display("FAIL wd_before: got busy,timeout_err=%b want 10", {busy, timeout_err}); else n_pass++;
    step();                       // edge N+255: abort
    if (bus.rd_done === 1'b1) saw_done = 1'b1;
    n_chk++; if ({busy, timeout_err, bus.app_req} !== 3'b010) $display("FAIL wd_abort: got busy,timeout_err,app_req=%b want 010", {busy, timeout_err, bus.app_req}); else n_pass++;
    n_chk++; if (saw_done !== 1'b0) $display("FAIL wd_no_done: got rd_done pulse want none"); else n_pass++;
    bus.wr_addr = 25'h00042;
    bus.wr_data = 16'hBEEF;
    bus.wr_req  = 1'b1;
    step();
    bus.wr_req  = 1'b0;
    serve_one(wr_n, ok);
    n_chk++; if (!ok || wr_n !== 1'b0) $display("FAIL wd_next_grant: got ok=%0d wr_n=%b want ok=1 wr_n=0", ok, wr_n); else n_pass++;
    n_chk++; if (bus.wr_done !== 1'b1) $display("FAIL wd_next_done: got %b want 1", bus.wr_done); else n_pass++;
    n_chk++; if (timeout_err !== 1'b1) $display("FAIL wd_sticky: got %b want 1", timeout_err); else n_pass++;
    step();
  endtask

  task automatic test_reset_mid_and_not_ready();
    // Bring the arbiter into WAIT_WR, then reset it.
    bus.wr_addr = 25'h0F0F0;
    bus.wr_data = 16'hA5A5;
    bus.wr_req  = 1'b1;
    step();
    bus.app_req_ack = 1'b1;
    step();
    bus.app_req_ack = 1'b0;
    bus.wr_req      = 1'b0;
    step();
    n_chk++; if (busy !== 1'b1) $display("FAIL mid_in_wait: got busy=%b want 1", busy); else n_pass++;
    rst = 1'b1;
    step();
    n_chk++; if ({bus.app_req, busy, timeout_err, bus.app_req_wr_n} !== 4'b0001)
      $display("FAIL mid_reset: got app_req,busy,timeout_err,wr_n=%b want 0001", {bus.app_req, busy, timeout_err, bus.app_req_wr_n}); else n_pass++;
    n_chk++; if (bus.app_wr_data !== 16'd0) $display("FAIL mid_reset_wdata: got %h want 0", bus.app_wr_data); else n_pass++;
    // Release reset with the controller not ready and a request pending.
    mem_ready  = 1'b0;
    bus.wr_req = 1'b1;
    rst        = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      n_chk++; if ({bus.app_req, busy} !== 2'b00) $display("FAIL not_ready_%0d: got app_req,busy=%b want 00", i, {bus.app_req, busy}); else n_pass++;
    end
    mem_ready = 1'b1;
    step();
    n_chk++; if ({bus.app_req, bus.app_req_wr_n} !== 2'b10) $display("FAIL ready_grant: got app_req,wr_n=%b want 10", {bus.app_req, bus.app_req_wr_n}); else n_pass++;
    // mem_ready drops mid-transaction: finish it, then grant nothing.
    bus.app_req_ack = 1'b1;
    step();
    bus.app_req_ack = 1'b0;
    mem_ready       = 1'b0;     // wr_req stays high as a fresh request
    bus.app_last_wr = 1'b1;
    step();
    n_chk++; if (bus.wr_done !== 1'b1) $display("FAIL drop_ready_done: got %b want 1", bus.wr_done); else n_pass++;
    bus.app_last_wr = 1'b0;
    step();
    step();
    n_chk++; if ({bus.app_req, busy} !== 2'b00) $display("FAIL drop_ready_nogrant: got app_req,busy=%b want 00", {bus.app_req, busy}); else n_pass++;
    bus.wr_req = 1'b0;
    mem_ready  = 1'b1;
    step();
  endtask

  initial begin
    rst       = 1'b1;
    mem_ready = 1'b0;
    clear_inputs();
    #1;
    test_reset();
    test_single_read();
    test_single_write();
    test_starvation();
    test_urgent();
    test_watchdog();
    test_reset_mid_and_not_ready();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, %0d/%0d so far", n_pass, n_chk);
    $fatal(1, "bench timeout");
  end

endmodule
